// File: rtl/ds_pkg.sv
// Shared constants for the data-selector family: mode encodings and default sizes.
package ds_pkg;
    localparam logic DS_MODE_FIXED = 1'b0;
    localparam logic DS_MODE_RR    = 1'b1;
    localparam int   DS_WIDTH      = 32;
    localparam int   DS_NUM        = 4;
endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: picks the first asserted request at or after base,
// wrapping modulo NUM. Purely combinational.
module rr_pick
    import ds_pkg::*;
#(
    parameter  int NUM   = DS_NUM,
    localparam int SEL_W = $clog2(NUM)
) (
    input  logic [NUM-1:0]   req,
    input  logic [SEL_W-1:0] base,
    output logic [NUM-1:0]   gnt,
    output logic [SEL_W-1:0] gnt_idx,
    output logic             any
);

    logic [SEL_W-1:0] idx;

    // Scan from the farthest position back to base so the nearest hit wins last.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = '0;
        for (int k = NUM - 1; k >= 0; k--) begin
            idx = SEL_W'((int'(base) + k) % NUM);
            if (req[idx]) begin
                gnt      = '0;
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ds_n_arb.sv
// N-way registered data selector with fixed-select or round-robin arbitration
// and valid/ready handshakes on both sides.
module ds_n_arb
    import ds_pkg::*;
#(
    parameter  int WIDTH = DS_WIDTH,
    parameter  int NUM   = DS_NUM,
    localparam int SEL_W = $clog2(NUM)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mode,
    input  logic [SEL_W-1:0]     sel,
    input  logic [NUM-1:0]       in_valid,
    input  logic [NUM*WIDTH-1:0] in_data,
    output logic [NUM-1:0]       in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [SEL_W-1:0]     out_src,
    input  logic                 out_ready
);

    logic [SEL_W-1:0] ptr;
    logic [NUM-1:0]   rr_gnt;
    logic [SEL_W-1:0] rr_idx;
    logic             rr_any;
    logic [NUM-1:0]   fixed_gnt;
    logic [NUM-1:0]   grant;
    logic [SEL_W-1:0] g_idx;
    logic             g_any;
    logic [WIDTH-1:0] sel_data;
    logic             can_accept;
    logic             accept;

    rr_pick #(.NUM(NUM)) u_rr_pick (
        .req     (in_valid),
        .base    (ptr),
        .gnt     (rr_gnt),
        .gnt_idx (rr_idx),
        .any     (rr_any)
    );

    // A select value beyond the last channel matches no bit and grants nothing.
    always_comb begin
        fixed_gnt = '0;
        for (int i = 0; i < NUM; i++) begin
            fixed_gnt[i] = in_valid[i] & (sel == SEL_W'(i));
        end
    end

    always_comb begin
        if (mode == DS_MODE_RR) begin
            grant = rr_gnt;
            g_idx = rr_idx;
            g_any = rr_any;
        end else begin
            grant = fixed_gnt;
            g_idx = sel;
            g_any = |fixed_gnt;
        end
    end

    // One-hot AND-OR mux keeps ungranted (possibly X) channels out of the register.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM; i++) begin
            if (grant[i]) begin
                sel_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign can_accept = ~out_valid | out_ready;
    assign accept     = can_accept & g_any;
    assign in_ready   = (can_accept & rst_n) ? grant : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            ptr       <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_src   <= g_idx;
            if (mode == DS_MODE_RR) begin
                ptr <= (g_idx == SEL_W'(NUM - 1)) ? '0 : g_idx + 1'b1;
            end
        end else if (out_valid & out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ds_n_arb.sv
// Scoreboard bench for ds_n_arb: a reference grant model predicts in_ready and
// queues accepted words, which are compared while the output holds them.
module tb_ds_n_arb;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         mode;
    logic [1:0]   sel;
    logic [3:0]   in_valid;
    logic [127:0] in_data;
    logic [3:0]   in_ready;
    logic         out_valid;
    logic [31:0]  out_data;
    logic [1:0]   out_src;
    logic         out_ready;
    logic [31:0]  chData [4];

    logic         mode5;
    logic [2:0]   sel5;
    logic [4:0]   valid5;
    logic [159:0] data5;
    logic [4:0]   ready5;
    logic         ov5;
    logic [31:0]  od5;
    logic [2:0]   os5;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  src;
    } exp_t;

    exp_t sbq[$];
    int   nChecks = 0;
    int   nPassed = 0;
    logic mValid;
    int   mPtr;

    always #5 clk = ~clk;

    assign in_data = {chData[3], chData[2], chData[1], chData[0]};

    ds_n_arb #(.WIDTH(32), .NUM(4)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
        .out_ready(out_ready)
    );

    ds_n_arb #(.WIDTH(32), .NUM(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .mode(mode5), .sel(sel5),
        .in_valid(valid5), .in_data(data5), .in_ready(ready5),
        .out_valid(ov5), .out_data(od5), .out_src(os5),
        .out_ready(1'b1)
    );

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got === exp) nPassed++;
        else $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int modelGrant(input logic m, input logic [1:0] s, input logic [3:0] v, input int p);
        if (!m) return v[s] ? int'(s) : -1;
        for (int k = 0; k < 4; k++) begin
            if (v[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic randData();
        for (int i = 0; i < 4; i++) chData[i] = $urandom;
    endtask

    // Entered between edges; drives, checks before the edge, returns 1 time unit after it.
    task automatic applyStimulus(input logic m, input logic [1:0] s, input logic [3:0] v, input logic ordy);
        int         g;
        logic       canAcc;
        logic [3:0] expRdy;
        exp_t       e;
        mode = m; sel = s; in_valid = v; out_ready = ordy;
        #2;
        g      = modelGrant(m, s, v, mPtr);
        canAcc = !mValid || ordy;
        expRdy = (canAcc && g >= 0) ? 4'(1 << g) : 4'b0000;
        checkOutput("in_ready", in_ready, expRdy);
        checkOutput("out_valid", out_valid, mValid);
        if (mValid) begin
            checkOutput("sb_depth", sbq.size(), 1);
            if (sbq.size() > 0) begin
                checkOutput("out_data", out_data, sbq[0].data);
                checkOutput("out_src", out_src, sbq[0].src);
                if (ordy) void'(sbq.pop_front());
            end
        end
        if (canAcc && g >= 0) begin
            e.data = chData[g];
            e.src  = 2'(g);
            sbq.push_back(e);
            mValid = 1'b1;
            if (m) mPtr = (g + 1) % 4;
        end else if (mValid && ordy) begin
            mValid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0; mode = 1'b0; sel = 2'd0; in_valid = 4'hF; out_ready = 1'b1;
        mode5 = 1'b0; sel5 = 3'd0; valid5 = 5'h00; data5 = {$urandom, $urandom, $urandom, $urandom, $urandom};
        mValid = 1'b0; mPtr = 0;
        randData();

        // Reset with every channel valid
        #23;
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_data", out_data, 0);
        checkOutput("rst_out_src", out_src, 0);
        checkOutput("rst_in_ready", in_ready, 4'b0000);
        @(posedge clk); #1;
        rst_n = 1'b1;
        applyStimulus(1'b1, 2'd0, 4'hF, 1'b1);

        // Fixed select of channel 2
        randData(); chData[2] = 32'hDEAD_BEEF;
        applyStimulus(1'b0, 2'd2, 4'b0100, 1'b1);
        checkOutput("fixed_data", out_data, 32'hDEAD_BEEF);
        checkOutput("fixed_src", out_src, 2);
        randData();
        applyStimulus(1'b0, 2'd2, 4'b0000, 1'b1);

        // Round robin with all channels valid
        for (int i = 0; i < 5; i++) begin
            randData();
            applyStimulus(1'b1, 2'd0, 4'hF, 1'b1);
        end

        // Backpressure, then drain plus accept in one cycle
        for (int i = 0; i < 3; i++) begin
            randData();
            applyStimulus(1'b1, 2'd0, 4'hF, 1'b0);
        end
        for (int i = 0; i < 2; i++) begin
            randData();
            applyStimulus(1'b1, 2'd0, 4'hF, 1'b1);
        end

        // Move ptr to 3, then wrap between channels 3 and 0
        randData();
        applyStimulus(1'b1, 2'd0, 4'b0100, 1'b1);
        checkOutput("ptr_setup_src", out_src, 2);
        for (int i = 0; i < 3; i++) begin
            randData();
            applyStimulus(1'b1, 2'd0, 4'b1001, 1'b1);
        end
        applyStimulus(1'b1, 2'd0, 4'b0000, 1'b1);
        applyStimulus(1'b1, 2'd0, 4'b0000, 1'b1);

        // Five-channel build: select 5 grants nothing, select 4 works
        mode5 = 1'b0; sel5 = 3'd5; valid5 = 5'h1F;
        #1;
        checkOutput("n5_sel5_ready", ready5, 5'b00000);
        applyStimulus(1'b1, 2'd0, 4'b0000, 1'b1);
        checkOutput("n5_sel5_valid", ov5, 0);
        sel5 = 3'd4;
        #1;
        checkOutput("n5_sel4_ready", ready5, 5'b10000);
        applyStimulus(1'b1, 2'd0, 4'b0000, 1'b1);
        checkOutput("n5_sel4_valid", ov5, 1);
        checkOutput("n5_sel4_src", os5, 4);
        checkOutput("n5_sel4_data", od5, data5[4*32 +: 32]);
        valid5 = 5'h00;

        // Random mix of modes, selects, valids and backpressure
        for (int i = 0; i < 30; i++) begin
            randData();
            applyStimulus(1'($urandom), 2'($urandom), 4'($urandom), 1'($urandom));
        end

        // Async reset between clock edges while streaming
        randData();
        applyStimulus(1'b1, 2'd0, 4'hF, 1'b1);
        randData();
        applyStimulus(1'b1, 2'd0, 4'hF, 1'b1);
        checkOutput("pre_rst_valid", out_valid, 1);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_valid", out_valid, 0);
        checkOutput("async_rst_ready", in_ready, 4'b0000);
        mValid = 1'b0; mPtr = 0; sbq.delete();
        @(posedge clk); #2;
        rst_n = 1'b1;
        randData();
        applyStimulus(1'b1, 2'd0, 4'b0110, 1'b1);
        checkOutput("post_rst_src", out_src, 1);
        applyStimulus(1'b1, 2'd0, 4'b0000, 1'b1);

        $display("%0d/%0d checks passed", nPassed, nChecks);
        $finish;
    end

endmodule
